im_loader: RTL and testbench
============================

# im_loader

Boot-time writer for the single-cycle processor's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian WL-bit instruction words, and drives the instruction memory's write port at consecutive word addresses starting from 0. It holds the processor core in reset until a complete, well-formed image has been written.

## Interface
- WL, 32, instruction word width in bits; must be a multiple of 8
- DEPTH, 13, instruction memory depth in words; range 1..255
- AW, $clog2(DEPTH), width of the word-address field
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; ignored while busy
- in_valid  in  1  the byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- IMWA  out  AW  instruction memory write word address
- IMWD  out  WL  instruction memory write data
- IMWE  out  1  write strobe, one cycle per word
- busy  out  1  a load is in progress
- done  out  1  sticky; the last load completed successfully
- err  out  1  sticky; the last load was aborted
- cpu_rst_n  out  1  active-low reset to the core; low unless done

## Operation
- Image format: one header byte N (the word count), then N×(WL/8) data bytes, least-significant byte first.
- States:
  - IDLE
    - start → HDR. Clears done and err, zeroes the word address, byte counter and checksum.
  - HDR
    - Accepts a byte. N == 0 or N > DEPTH → ERR.
    - Otherwise latch N → DATA.
  - DATA
    - Each accepted byte shifts into the word assembly register at lane byte_cnt.
    - When the last byte of a word is accepted, issue the write.
    - After word N-1: → CSUM if LOADER_CHECKSUM_EN, else → DONE.
  - CSUM
    - Accepts one byte. If (header + all data bytes + this byte) mod 256 == 0 → DONE, else → ERR.
  - DONE
    - Sets done and releases cpu_rst_n. → IDLE on the next cycle; done stays set.
  - ERR
    - Sets err. → IDLE on the next cycle; err stays set.
- Handshake:
  - in_ready = 1 only in HDR, DATA and CSUM.
  - A byte transfers only on a cycle with in_valid && in_ready.
  - in_valid low stalls the loader with no state change and no timeout.
- Write port:
  - IMWA, IMWD and IMWE are registered.
  - IMWE is high for exactly one cycle per word.
  - IMWA increments after each write. No wrap-around is possible because N ≤ DEPTH.
- cpu_rst_n:
  - 0 from reset until the DONE state.
  - Driven to 0 again on start.
  - Stays 0 after ERR.
- start while busy: ignored, with no effect on the load in progress.
- start and the final byte in the same cycle: start is ignored; the load completes normally.

## Timing
- Reset values: every state register is IDLE; in_ready=0, IMWA=0, IMWD=0, IMWE=0, busy=0, done=0, err=0, cpu_rst_n=0.
- Reset mid-load aborts immediately to the reset values. The memory contents are left partially written.
- start at cycle t: busy=1 and in_ready=1 from cycle t+1.
- Final data byte accepted at edge t: IMWE=1 during cycle t+1, with IMWA and IMWD valid in that same cycle.
- Without checksum:
  - DONE occupies cycle t+1.
  - done=1 and cpu_rst_n=1 from cycle t+2.
  - busy falls at t+2.
- With checksum: the checksum byte accepted at edge u gives done/err=1 from cycle u+2.
- Minimum load length for N words: 1 + N·WL/8 accepted bytes, plus 1 with the checksum, plus 2 cycles.
- busy = 1 in every state except IDLE.

## Configuration
- LOADER_CHECKSUM_EN
  - Defined: the CSUM state exists, and an image carries one trailing 2's-complement checksum byte.
  - Undefined: CSUM is removed, and DATA goes directly to DONE.

## Structure
- Shared package holds:
  - the state enum (IDLE, HDR, DATA, CSUM, DONE, ERR);
  - BYTES_PER_WORD = WL/8;
  - the header and checksum width (8).
- No sub-module; a single flat FSM with a datapath. The instruction memory itself is instantiated beside the loader, not inside it.

## Test plan
- Reset asserted mid-DATA: all outputs return to their reset values asynchronously; no IMWE pulse follows.
- Load of N=2 with bytes 00,00,20,08 and 13,00,01,20 (checksum off):
  - IMWE at IMWA=0 with IMWD=0x08200000;
  - IMWE at IMWA=1 with IMWD=0x20010013;
  - then done=1 and cpu_rst_n=1.
- Header 0x00 → err=1, cpu_rst_n=0, and no IMWE. Header 0x0E with DEPTH=13 → same result.
- Random in_valid gaps with N=13:
  - exactly 13 IMWE pulses at addresses 0..12;
  - data matches the stream;
  - no byte is dropped or duplicated.
- With LOADER_CHECKSUM_EN, N=1, bytes 01 | 01 02 03 04 | F5 → done=1. Repeating with a checksum byte of F6 → err=1.
- start pulsed during DATA → ignored; the load completes unchanged. A second start after done → done clears and cpu_rst_n goes to 0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: state encoding, byte-lane and header/checksum widths shared by the boot loader
package im_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W = 8;
  localparam int CSUM_W = 8;
  function automatic int bytes_per_word(input int wl);
    return wl / 8;
  endfunction
endpackage

// File: rtl/im_loader.sv
// im_loader: streams a byte image into instruction memory and holds the core in reset until it is complete (LOADER_CHECKSUM_EN adds a trailing checksum byte)
module im_loader
  import im_loader_pkg::*;
#(
  parameter int WL = 8 * BYTES_PER_WORD,
  parameter int DEPTH = 13,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] IMWA,
  output logic [WL-1:0] IMWD,
  output logic          IMWE,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_rst_n
);
  localparam int BPW = bytes_per_word(WL);
  localparam int BCW = BPW > 1 ? $clog2(BPW) : 1;
  state_t state_q, state_d;
  logic [HDR_W-1:0] n_q, n_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [AW-1:0] wcnt_q, wcnt_d, imwa_q, imwa_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [WL-1:0] word_q, word_d, imwd_q, imwd_d;
  logic imwe_q, imwe_d, done_q, done_d, err_q, err_d, crst_q, crst_d;
  logic xfer, last_byte, last_word;
  assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign busy = state_q != IDLE;
  assign xfer = in_valid && in_ready;
  assign last_byte = bcnt_q == BCW'(BPW - 1);
  assign last_word = HDR_W'(wcnt_q) == n_q - 1'b1;
  assign IMWA = imwa_q;
  assign IMWD = imwd_q;
  assign IMWE = imwe_q;
  assign done = done_q;
  assign err = err_q;
  assign cpu_rst_n = crst_q;
  // Next state, byte assembly, checksum accumulation and write-port staging
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    csum_d = csum_q;
    wcnt_d = wcnt_q;
    imwa_d = imwa_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    imwd_d = imwd_q;
    imwe_d = 1'b0;
    done_d = done_q;
    err_d = err_q;
    crst_d = crst_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR;
        done_d = 1'b0;
        err_d = 1'b0;
        crst_d = 1'b0;
        wcnt_d = '0;
        imwa_d = '0;
        bcnt_d = '0;
        csum_d = '0;
      end
      HDR: if (xfer) begin
        csum_d = in_data;
        n_d = in_data;
        state_d = (in_data == 8'd0 || in_data > 8'(DEPTH)) ? ERR : DATA;
      end
      DATA: if (xfer) begin
        csum_d = csum_q + in_data;
        word_d[8*bcnt_q +: 8] = in_data;
        bcnt_d = last_byte ? '0 : bcnt_q + 1'b1;
        if (last_byte) begin
          imwe_d = 1'b1;
          imwa_d = wcnt_q;
          imwd_d = word_d;
          wcnt_d = wcnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          if (last_word) state_d = CSUM;
`else
          if (last_word) state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (xfer) state_d = (CSUM_W'(csum_q + in_data) == '0) ? DONE : ERR;
`endif
      DONE: begin
        done_d = 1'b1;
        crst_d = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset mid-load drops straight back to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      csum_q <= '0;
      wcnt_q <= '0;
      imwa_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      imwd_q <= '0;
      imwe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      crst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      csum_q <= csum_d;
      wcnt_q <= wcnt_d;
      imwa_q <= imwa_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      imwd_q <= imwd_d;
      imwe_q <= imwe_d;
      done_q <= done_d;
      err_q <= err_d;
      crst_q <= crst_d;
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed and randomized image loads checked against a byte-stream reference model
module tb_im_loader;
  localparam int WL = 32;
  localparam int DEPTH = 13;
  localparam int AW = 4;
  localparam int BPW = WL / 8;
  logic clk, rst_n, start, in_valid, in_ready, IMWE, busy, done, err, cpu_rst_n;
  logic [7:0] in_data;
  logic [AW-1:0] IMWA;
  logic [WL-1:0] IMWD;
  int vectors = 0;
  int miscompares = 0;
  logic [AW-1:0] alog[$];
  logic [WL-1:0] wlog[$];
  logic [7:0] img[$];
  im_loader #(.WL(WL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .IMWA(IMWA), .IMWD(IMWD), .IMWE(IMWE), .busy(busy),
    .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (IMWE) begin
    alog.push_back(IMWA);
    wlog.push_back(IMWD);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] csum_of(input logic [7:0] b[$]);
    logic [7:0] s = 8'd0;
    foreach (b[i]) s += b[i];
    return -s;
  endfunction
`endif
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic load(input logic [7:0] b[$], input int gapmax, input int start_at);
    int k = 0;
    alog.delete();
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err, 0);
    check("start_cpu_rst", cpu_rst_n, 0);
    foreach (b[i]) begin
      if (i == start_at) start = 1'b1;
      send_byte(b[i], i == start_at ? 0 : $urandom_range(0, gapmax));
    end
    while (busy && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("load_idle", busy, 0);
  endtask
  task automatic verify(input string tag, input logic [7:0] b[$]);
    int n, expn;
    bit ok;
    logic [WL-1:0] w;
    n = b[0];
    ok = n >= 1 && n <= DEPTH;
    expn = ok ? n : 0;
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] s = 8'd0;
      foreach (b[i]) s += b[i];
      ok = ok && s == 8'd0;
    end
`endif
    check({tag, "_done"}, done, ok);
    check({tag, "_err"}, err, !ok);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, ok);
    check({tag, "_nwrites"}, alog.size(), expn);
    for (int i = 0; i < expn && i < alog.size(); i++) begin
      w = '0;
      for (int k = 0; k < BPW; k++) w |= WL'(b[1 + i * BPW + k]) << (8 * k);
      check({tag, "_addr"}, alog[i], i);
      check({tag, "_data"}, wlog[i], w);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_imwa", IMWA, 0);
    check("rst_imwd", IMWD, 0);
    check("rst_imwe", IMWE, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    img = {8'h02, 8'h00, 8'h00, 8'h20, 8'h08, 8'h13, 8'h00, 8'h01, 8'h20};
    alog.delete();
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("n2_busy", busy, 1);
    foreach (img[i]) send_byte(img[i], 0);
    check("n2_imwe", IMWE, 1);
    check("n2_imwa", IMWA, 1);
    check("n2_imwd", IMWD, 32'h20010013);
`ifdef LOADER_CHECKSUM_EN
    check("n2_csum_wait", done, 0);
    img.push_back(csum_of(img));
    send_byte(img[9], 0);
`endif
    check("n2_done_state_done", done, 0);
    check("n2_done_state_busy", busy, 1);
    @(negedge clk);
    check("n2_done", done, 1);
    check("n2_cpu_rst_n", cpu_rst_n, 1);
    check("n2_busy_fall", busy, 0);
    check("n2_imwe_once", IMWE, 0);
    verify("n2", img);
    check("n2_first_word", wlog.size() > 0 ? wlog[0] : 'x, 32'h08200000);
    img = {8'h00};
    load(img, 0, -1);
    verify("hdr0", img);
    img = {8'h0E};
    load(img, 2, -1);
    verify("hdr14", img);
    img = {8'd13};
    repeat (13 * BPW) img.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
    img.push_back(csum_of(img));
`endif
    load(img, 3, -1);
    verify("n13_gaps", img);
    img = {8'd3};
    repeat (3 * BPW) img.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
    img.push_back(csum_of(img));
`endif
    load(img, 1, 5);
    verify("start_mid", img);
    img = {8'd1};
    repeat (BPW) img.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
    img.push_back(csum_of(img));
`endif
    load(img, 1, img.size() - 1);
    verify("start_last", img);
`ifdef LOADER_CHECKSUM_EN
    img = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    load(img, 1, -1);
    verify("cs_good", img);
    check("cs_good_flag", done, 1);
    img[5] = 8'hF6;
    load(img, 1, -1);
    verify("cs_bad", img);
    check("cs_bad_flag", err, 1);
`endif
    img = {8'd3};
    repeat (3 * BPW) img.push_back(8'($urandom_range(1, 255)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 2 * BPW; i++) send_byte(img[i], 0);
    check("mid_imwa_pre", IMWA, 1);
    in_valid = 1'b1;
    in_data = img[2 * BPW + 1];
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 0);
    check("arst_imwa", IMWA, 0);
    check("arst_imwd", IMWD, 0);
    check("arst_imwe", IMWE, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_cpu_rst_n", cpu_rst_n, 0);
    alog.delete();
    wlog.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_imwe", alog.size(), 0);
    check("arst_idle", busy, 0);
    img = {8'd2};
    repeat (2 * BPW) img.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
    img.push_back(csum_of(img));
`endif
    load(img, 2, -1);
    verify("recover", img);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
